// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side program-counter sequencer.
package pc_seq_pkg;

  localparam int WIDTHPC_DEF    = 30;
  localparam int WIDTHINSTR_DEF = 32;

  // Word addresses; byte addresses are these shifted left by two.
  localparam logic [WIDTHPC_DEF-1:0] RESET_ADDR_DEF = 30'h0010_0000;
  localparam logic [WIDTHPC_DEF-1:0] EXC_ADDR_DEF   = 30'h2000_0060;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2,
    PC_EXC  = 2'd3
  } pc_sel_t;

endpackage

// File: rtl/adder.sv
// Plain modulo-2^DATA_WIDTH adder; used here as the pc+1 incrementer.
module adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_op1,
  input  logic [DATA_WIDTH-1:0] i_op2,
  output logic [DATA_WIDTH-1:0] o_result
);

  assign o_result = i_op1 + i_op2;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the fetch PC, issues one instruction-memory request at a time and
// presents each returned instruction to decode until it is accepted.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                   WIDTHPC    = WIDTHPC_DEF,
  parameter int                   WIDTHINSTR = WIDTHINSTR_DEF,
  parameter logic [WIDTHPC-1:0]   RESET_ADDR = WIDTHPC'(RESET_ADDR_DEF),
  parameter logic [WIDTHPC-1:0]   EXC_ADDR   = WIDTHPC'(EXC_ADDR_DEF)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_PCSrc,
  input  logic [WIDTHPC-1:0]    i_addr,
  input  logic                  i_flush,
  output logic                  o_imem_req,
  output logic [WIDTHPC-1:0]    o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [WIDTHINSTR-1:0] i_imem_data,
  output logic [WIDTHINSTR-1:0] o_instr,
  output logic                  o_instr_valid,
  output logic [WIDTHPC-1:0]    o_pc,
  output logic [WIDTHPC-1:0]    o_incPC,
  output state_t                o_state
);

  // Handshakes: a memory transfer happens on a cycle with o_imem_req & i_imem_ack,
  // and req/addr stay stable until then; decode takes the instruction on a cycle
  // with o_instr_valid & ~i_stall, and the outputs hold while it stalls.

  state_t              state;
  state_t              state_next;
  pc_sel_t             pc_sel;
  logic                capture;
  logic                fp_set;
  logic                fp_clr;
  logic                flush_pend;
  logic [WIDTHPC-1:0]  pc;
  logic [WIDTHPC-1:0]  pc_inc;

  adder #(.DATA_WIDTH(WIDTHPC)) u_inc (
    .i_op1    (pc),
    .i_op2    (WIDTHPC'(1)),
    .o_result (pc_inc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (i_imem_ack && !flush_pend && !i_flush) state_next = DELIVER;
      DELIVER: if (i_flush || !i_stall) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    capture       = 1'b0;
    fp_set        = 1'b0;
    fp_clr        = 1'b0;
    pc_sel        = PC_HOLD;
    unique case (state)
      IDLE: if (i_flush) pc_sel = PC_EXC;
      FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          // A flush seen before or with the ack makes the returned word stale.
          if (flush_pend || i_flush) begin
            pc_sel = PC_EXC;
            fp_clr = 1'b1;
          end else begin
            capture = 1'b1;
            pc_sel  = PC_INC;
          end
        end else if (i_flush) begin
          fp_set = 1'b1;
        end
      end
      DELIVER: begin
        o_instr_valid = 1'b1;
        if (i_flush)                  pc_sel = PC_EXC;
        else if (!i_stall && i_PCSrc) pc_sel = PC_TGT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc         <= RESET_ADDR;
      flush_pend <= 1'b0;
      o_instr    <= '0;
      o_pc       <= '0;
      o_incPC    <= '0;
    end else begin
      unique case (pc_sel)
        PC_INC:  pc <= pc_inc;
        PC_TGT:  pc <= i_addr;
        PC_EXC:  pc <= EXC_ADDR;
        default: pc <= pc;
      endcase
      if (fp_set)      flush_pend <= 1'b1;
      else if (fp_clr) flush_pend <= 1'b0;
      if (capture) begin
        o_instr <= i_imem_data;
        o_pc    <= pc;
        o_incPC <= pc_inc;
      end
    end
  end

  assign o_imem_addr = pc;
  assign o_state     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a transaction-level model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int W  = WIDTHPC_DEF;
  localparam int IW = WIDTHINSTR_DEF;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          pcsrc = 1'b0;
  logic [W-1:0]  addr = '0;
  logic          flush = 1'b0;
  logic          ack = 1'b0;
  logic [IW-1:0] data = '0;

  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [W-1:0]  pc_out;
  logic [W-1:0]  inc_pc;
  state_t        dbg_state;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_PCSrc       (pcsrc),
    .i_addr        (addr),
    .i_flush       (flush),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (ack),
    .i_imem_data   (data),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc_out),
    .o_incPC       (inc_pc),
    .o_state       (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // waiting: a word is owed by memory; holding: decode has an instruction.
  typedef enum {M_IDLE, M_WAIT, M_HOLD} mode_t;
  mode_t         m_mode;
  logic [W-1:0]  m_next;
  logic [W-1:0]  m_opc;
  logic [W-1:0]  m_inc;
  bit            m_stale;
  logic [IW-1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  = M_IDLE;
      m_next  = RESET_ADDR_DEF;
      m_stale = 1'b0;
      m_opc   = '0;
      m_inc   = '0;
      exp_q.delete();
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (flush) m_next = EXC_ADDR_DEF;
          m_mode = M_WAIT;
        end
        M_WAIT: begin
          if (ack) begin
            if (m_stale || flush) begin
              m_next  = EXC_ADDR_DEF;
              m_stale = 1'b0;
            end else begin
              exp_q.push_back(data);
              m_opc  = m_next;
              m_inc  = W'(m_next + 1);
              m_next = W'(m_next + 1);
              m_mode = M_HOLD;
            end
          end else if (flush) begin
            m_stale = 1'b1;
          end
        end
        default: begin
          if (flush || !stall) begin
            if (flush)      m_next = EXC_ADDR_DEF;
            else if (pcsrc) m_next = addr;
            m_mode = M_WAIT;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      endcase
    end
  end

  // ---------------- compare (every cycle) ----------------
  always @(negedge clk) begin
    chk("req",   32'(imem_req),    32'(m_mode == M_WAIT));
    chk("addr",  32'(imem_addr),   32'(m_next));
    chk("valid", 32'(instr_valid), 32'(m_mode == M_HOLD));
    chk("pc",    32'(pc_out),      32'(m_opc));
    chk("incpc", 32'(inc_pc),      32'(m_inc));
    if (m_mode == M_HOLD && exp_q.size() > 0) chk("instr", instr, exp_q[0]);
  end

  // ---------------- driver ----------------
  task automatic drive(input bit st, input bit src, input logic [W-1:0] a,
                       input bit fl, input bit ak, input logic [IW-1:0] d);
    stall = st;
    pcsrc = src;
    addr  = a;
    flush = fl;
    ack   = ak;
    data  = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [IW-1:0] d0;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr,            32'h0);
    chk("rst_pc",    32'(pc_out),      32'h0);
    chk("rst_incpc", 32'(inc_pc),      32'h0);
    chk("rst_addr",  32'(imem_addr),   32'h0010_0000);
    rst = 1'b0;

    // Sequential fetch with immediate acks
    drive(0, 0, '0, 0, 1, 32'h1111_0000);
    chk("seq_req0",  32'(imem_req),  32'h1);
    chk("seq_addr0", 32'(imem_addr), 32'h0010_0000);
    d0 = 32'hA5A5_0001;
    drive(0, 0, '0, 0, 1, d0);
    chk("seq_valid0", 32'(instr_valid), 32'h1);
    chk("seq_instr0", instr,            d0);
    chk("seq_pc0",    32'(pc_out),      32'h0010_0000);
    chk("seq_inc0",   32'(inc_pc),      32'h0010_0001);
    drive(0, 0, '0, 0, 1, 32'h0);
    chk("seq_valid1", 32'(instr_valid), 32'h0);
    chk("seq_addr1",  32'(imem_addr),   32'h0010_0001);
    drive(0, 0, '0, 0, 1, 32'hA5A5_0002);
    drive(0, 0, '0, 0, 1, 32'h0);
    chk("seq_addr2", 32'(imem_addr), 32'h0010_0002);
    drive(0, 0, '0, 0, 1, 32'hA5A5_0003);
    chk("seq_pc2", 32'(pc_out), 32'h0010_0002);

    // Stall holds outputs and ignores the redirect
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, W'(32'h123), 0, 0, 32'h0);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_pc",    32'(pc_out),      32'h0010_0002);
    end
    drive(0, 1, W'(32'h123), 0, 0, 32'h0);
    chk("redir_req",  32'(imem_req),  32'h1);
    chk("redir_addr", 32'(imem_addr), 32'h0000_0123);

    // Flush while a request waits for a late ack
    drive(0, 0, '0, 1, 0, 32'h0);
    chk("fpend_addr0", 32'(imem_addr), 32'h0000_0123);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 0, 0, 32'h0);
      chk("fpend_addr", 32'(imem_addr), 32'h0000_0123);
    end
    drive(0, 0, '0, 0, 1, 32'hDEAD_BEEF);
    chk("fpend_valid", 32'(instr_valid), 32'h0);
    chk("fpend_next",  32'(imem_addr),   32'h2000_0060);

    // Flush beats an unstalled redirect in DELIVER
    drive(0, 0, '0, 0, 1, 32'h0BAD_0001);
    chk("exc_pc", 32'(pc_out), 32'h2000_0060);
    drive(0, 1, W'(32'h55), 1, 0, 32'h0);
    chk("flush_win", 32'(imem_addr), 32'h2000_0060);

    // PC wrap-around
    drive(0, 0, '0, 0, 1, 32'h0BAD_0002);
    drive(0, 1, W'(32'h3FFF_FFFF), 0, 0, 32'h0);
    chk("wrap_addr", 32'(imem_addr), 32'h3FFF_FFFF);
    drive(0, 0, '0, 0, 1, 32'h0BAD_0003);
    chk("wrap_pc",  32'(pc_out), 32'h3FFF_FFFF);
    chk("wrap_inc", 32'(inc_pc), 32'h0);
    drive(0, 0, '0, 0, 0, 32'h0);
    chk("wrap_next", 32'(imem_addr), 32'h0);

    // Asynchronous reset mid-request
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #2 rst = 1'b1;
    #1 chk("async_req", 32'(imem_req), 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    chk("post_rst_idle", 32'(imem_req),  32'h0);
    drive(0, 0, '0, 0, 1, 32'h0);
    chk("post_rst_req",   32'(imem_req),    32'h1);
    chk("post_rst_addr",  32'(imem_addr),   32'h0010_0000);
    chk("post_rst_valid", 32'(instr_valid), 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit st, src, fl, ak;
      st  = ($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      ak  = (m_mode == M_HOLD) ? 1'b0 : ($urandom_range(0, 2) != 0);
      drive(st, src, W'($urandom), fl, ak, $urandom);
    end

    drive(0, 0, '0, 0, 0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the word-addressed program counter and sequences instruction-memory requests for the MIPS core. It presents one instruction at a time to decode along with its incremented PC, which feeds the next-PC branch/jump logic. It then applies that logic's redirect (PCSrc/target) or an exception flush to choose the next fetch address.

## Interface
Parameters:
- WIDTHPC, 30, word-address width (byte address [31:2])
- WIDTHINSTR, 32, instruction width
- RESET_ADDR, 30'h0010_0000, word address fetched after reset (byte 0x0040_0000)
- EXC_ADDR, 30'h2000_0060, word address loaded on flush (byte 0x8000_0180)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_stall  in  1  decode cannot accept the presented instruction this cycle
- i_PCSrc  in  1  redirect request from next-PC logic
- i_addr  in  WIDTHPC  redirect target word address
- i_flush  in  1  exception flush, one-cycle pulse, any state
- o_imem_req  out  1  instruction-memory request
- o_imem_addr  out  WIDTHPC  request word address
- i_imem_ack  in  1  memory returns data this cycle
- i_imem_data  in  WIDTHINSTR  instruction data, valid with ack
- o_instr  out  WIDTHINSTR  presented instruction
- o_instr_valid  out  1  o_instr is valid
- o_pc  out  WIDTHPC  word address of o_instr
- o_incPC  out  WIDTHPC  o_pc + 1, to next-PC logic

## Operation
- Registers: pc (next fetch address), flush_pend, instruction/pc/incPC output registers, 2-bit state.
- States: IDLE, FETCH, DELIVER.
- Reset (async): state=IDLE, pc=RESET_ADDR, flush_pend=0. All outputs are 0: o_imem_req, o_instr_valid, o_instr, o_pc, o_incPC. o_imem_addr equals pc.
- IDLE: lasts one cycle, then FETCH. i_flush here sets pc=EXC_ADDR.
- FETCH: o_imem_req=1, o_imem_addr=pc.
  - On ack with flush_pend=0 and i_flush=0: capture o_instr=i_imem_data, o_pc=pc, o_incPC=pc+1, pc<=pc+1. Move to DELIVER.
  - On ack with flush_pend=1 or i_flush=1: discard data, pc<=EXC_ADDR, clear flush_pend, stay FETCH.
  - i_flush without ack: set flush_pend and keep the outstanding request unchanged.
- DELIVER: o_instr_valid=1, o_imem_req=0.
  - Priority: i_flush > accepted redirect > accept > hold.
  - i_flush: pc<=EXC_ADDR, go to FETCH. The instruction is dropped even if i_stall=0.
  - i_stall=0 and i_PCSrc=1: pc<=i_addr, go to FETCH. No delay slot.
  - i_stall=0 and i_PCSrc=0: go to FETCH with pc (already +1).
  - i_stall=1: hold all outputs. i_PCSrc is ignored.
- i_PCSrc/i_addr are qualified only by o_instr_valid & ~i_stall and are ignored in IDLE and FETCH.
- Arithmetic: pc+1 is modulo 2^WIDTHPC; 30'h3FFF_FFFF wraps to 0. No sign handling.

## Timing
- Request protocol: o_imem_req and o_imem_addr are stable from assertion until the cycle i_imem_ack=1 is sampled. Ack in the same cycle req rises is legal.
- Data is captured on the ack edge. o_instr_valid rises the following cycle.
- Best-case throughput is one instruction per 2 cycles: FETCH with immediate ack, then DELIVER without stall.
- After an accepted redirect or flush in DELIVER, the next FETCH cycle drives o_imem_addr = new target.
- i_flush coincident with ack in FETCH discards that ack. The next cycle requests EXC_ADDR.
- Reset asserted mid-transaction drops the request immediately. A late ack after reset release is not expected; if one arrives in IDLE it is ignored.

## Structure
- Package pc_seq_pkg: state enum (IDLE, FETCH, DELIVER), WIDTHPC/WIDTHINSTR defaults, RESET_ADDR and EXC_ADDR constants.
- One sub-module: existing adder (DATA_WIDTH=WIDTHPC, i_op2=1) for pc+1. Everything else is inline.

## Test plan
- Reset, then ack every FETCH cycle: addresses 0x100000, 0x100001, 0x100002. o_incPC equals o_pc+1 and valid toggles every other cycle.
- In DELIVER, hold i_stall=1 for 3 cycles with i_PCSrc=1 and i_addr=0x123: outputs are held and PCSrc is ignored. Release the stall with i_PCSrc=1 and i_addr=0x123: next request addr=0x123.
- i_flush in FETCH with ack delayed 4 cycles: addr is held for 4 cycles, the data is discarded (no valid), and the next request is to 0x20000060.
- i_flush and i_PCSrc together in DELIVER, unstalled: the flush wins and the next request is to 0x20000060.
- Set pc to 0x3FFFFFFF via redirect: the fetch returns o_incPC=0 and the next request is addr 0.
- Assert i_rst asynchronously mid-FETCH: o_imem_req falls without waiting for a clock edge. After release, one IDLE cycle precedes a request to 0x100000.
